// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch redirect controller.
// A taken, aligned branch raises a redirect to fetch with a valid/ready
// handshake. Execute stays stalled while the redirect is pending and for
// FLUSH_CYCLES cycles afterwards, during which fetch/decode are flushed.
// A taken branch to a misaligned target raises a one-cycle exception pulse
// and does not redirect. Branch and redirect counts saturate at all-ones.
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_valid_ex,
    input  logic             jump_state_pre,
    input  logic [XLEN-1:0]  target_ex,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_pc,
    input  logic             redir_ready,
    output logic             flush_fd,
    output logic             stall_ex,
    output logic             misalign_exc,
    output logic [XLEN-1:0]  exc_tval,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REDIR = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [3:0]       r_fcnt;
    logic [XLEN-1:0]  r_redir_pc;
    logic             r_misalign;
    logic [XLEN-1:0]  r_exc_tval;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic w_resolve;
    logic w_taken;
    logic w_misaligned;
    logic w_redirect;

    // Classify the branch presented in execute; only honoured while IDLE.
    always_comb begin
        w_resolve    = (r_state == IDLE) && branch_valid_ex;
        w_taken      = w_resolve && jump_state_pre;
        w_misaligned = w_taken && (target_ex[1:0] != 2'b00);
        w_redirect   = w_taken && (target_ex[1:0] == 2'b00);
    end

    // State machine, flush counter and captured redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fcnt     <= '0;
            r_redir_pc <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_redirect) begin
                        r_redir_pc <= target_ex;
                        r_state    <= REDIR;
                    end
                end
                REDIR: begin
                    if (redir_ready) begin
                        r_fcnt  <= FLUSH_INIT;
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (r_fcnt != 4'd0) begin
                        r_fcnt <= r_fcnt - 4'd1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Misaligned-target exception: pulse for one cycle, latch the bad target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
            r_exc_tval <= '0;
        end else begin
            r_misalign <= w_misaligned;
            if (w_misaligned) begin
                r_exc_tval <= target_ex;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (w_resolve && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (w_redirect && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + CNT_ONE;
            end
        end
    end

    assign redir_valid  = (r_state == REDIR);
    assign flush_fd     = (r_state != IDLE);
    assign stall_ex     = (r_state != IDLE);
    assign redir_pc     = r_redir_pc;
    assign misalign_exc = r_misalign;
    assign exc_tval     = r_exc_tval;
    assign branch_cnt   = r_branch_cnt;
    assign taken_cnt    = r_taken_cnt;

endmodule
